// File: rtl/mc_page_seq_pkg.sv
// Shared encodings for the SDRAM page command sequencer: command codes,
// FSM state codes and the wait-counter load helper.
package mc_page_seq_pkg;

    localparam logic [2:0] MC_CMD_NOP    = 3'd0;
    localparam logic [2:0] MC_CMD_PRE    = 3'd1;
    localparam logic [2:0] MC_CMD_PREALL = 3'd2;
    localparam logic [2:0] MC_CMD_ACT    = 3'd3;
    localparam logic [2:0] MC_CMD_RD     = 3'd4;
    localparam logic [2:0] MC_CMD_WR     = 3'd5;
    localparam logic [2:0] MC_CMD_REF    = 3'd6;

    localparam logic [3:0] MC_ST_IDLE   = 4'd0;
    localparam logic [3:0] MC_ST_PRE    = 4'd1;
    localparam logic [3:0] MC_ST_PRE_W  = 4'd2;
    localparam logic [3:0] MC_ST_ACT    = 4'd3;
    localparam logic [3:0] MC_ST_ACT_W  = 4'd4;
    localparam logic [3:0] MC_ST_COL    = 4'd5;
    localparam logic [3:0] MC_ST_PALL   = 4'd6;
    localparam logic [3:0] MC_ST_PALL_W = 4'd7;
    localparam logic [3:0] MC_ST_REF    = 4'd8;
    localparam logic [3:0] MC_ST_REF_W  = 4'd9;

    // The command cycle itself counts as the first of the spacing cycles.
    function automatic logic [3:0] mc_wait_load(input int cyc);
        return (cyc > 1) ? 4'(cyc - 2) : 4'd0;
    endfunction

endpackage

// File: rtl/mc_page_seq.sv
// Per-chip-select SDRAM page command sequencer (PRE/ACT/RD/WR/PREALL/REF).
// Define MC_AUTO_PRECHARGE_EN for close-page policy (RD/WR with auto-precharge).
module mc_page_seq
    import mc_page_seq_pkg::*;
#(
    parameter int TRP_CYC  = 2,
    parameter int TRCD_CYC = 2,
    parameter int TRFC_CYC = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_bank,
    input  logic [12:0] req_row,
    output logic        req_ack,
    input  logic        rfr_req,
    output logic        rfr_ack,
    input  logic        bank_open,
    input  logic        any_bank_open,
    input  logic        row_same,
    output logic [1:0]  bank_adr,
    output logic [12:0] row_adr,
    output logic        bank_set,
    output logic        bank_clr,
    output logic        bank_clr_all,
    output logic [2:0]  cmd,
    output logic        cmd_ap
);

    logic [3:0]  r_state;
    logic [3:0]  r_wcnt;
    logic        r_ap_rec;
    logic        r_we;
    logic [1:0]  r_bank;
    logic [12:0] r_row;

    logic [3:0]  w_nxt;
    logic        w_ld;
    logic [3:0]  w_ld_val;
    logic        w_wdone;

    assign w_wdone  = (r_wcnt == 4'd0);
    // The tracker must answer for the incoming request while still in IDLE.
    assign bank_adr = (r_state == MC_ST_IDLE) ? req_bank : r_bank;
    assign row_adr  = (r_state == MC_ST_IDLE) ? req_row  : r_row;

    always_comb begin
        w_nxt    = r_state;
        w_ld     = 1'b0;
        w_ld_val = 4'd0;
        case (r_state)
            MC_ST_IDLE: begin
                if (rfr_req)
                    w_nxt = any_bank_open ? MC_ST_PALL : MC_ST_REF;
                else if (req) begin
                    if (bank_open && row_same) w_nxt = MC_ST_COL;
                    else if (bank_open)        w_nxt = MC_ST_PRE;
                    else                       w_nxt = MC_ST_ACT;
                end
            end
            MC_ST_PRE: begin
                if (TRP_CYC > 1) begin
                    w_nxt = MC_ST_PRE_W; w_ld = 1'b1; w_ld_val = mc_wait_load(TRP_CYC);
                end else
                    w_nxt = MC_ST_ACT;
            end
            MC_ST_PRE_W:  if (w_wdone) w_nxt = r_ap_rec ? MC_ST_IDLE : MC_ST_ACT;
            MC_ST_ACT: begin
                if (TRCD_CYC > 1) begin
                    w_nxt = MC_ST_ACT_W; w_ld = 1'b1; w_ld_val = mc_wait_load(TRCD_CYC);
                end else
                    w_nxt = MC_ST_COL;
            end
            MC_ST_ACT_W:  if (w_wdone) w_nxt = MC_ST_COL;
            MC_ST_COL: begin
`ifdef MC_AUTO_PRECHARGE_EN
                if (TRP_CYC > 1) begin
                    w_nxt = MC_ST_PRE_W; w_ld = 1'b1; w_ld_val = mc_wait_load(TRP_CYC);
                end else
                    w_nxt = MC_ST_IDLE;
`else
                w_nxt = MC_ST_IDLE;
`endif
            end
            MC_ST_PALL: begin
                if (TRP_CYC > 1) begin
                    w_nxt = MC_ST_PALL_W; w_ld = 1'b1; w_ld_val = mc_wait_load(TRP_CYC);
                end else
                    w_nxt = MC_ST_REF;
            end
            MC_ST_PALL_W: if (w_wdone) w_nxt = MC_ST_REF;
            MC_ST_REF: begin
                if (TRFC_CYC > 1) begin
                    w_nxt = MC_ST_REF_W; w_ld = 1'b1; w_ld_val = mc_wait_load(TRFC_CYC);
                end else
                    w_nxt = MC_ST_IDLE;
            end
            MC_ST_REF_W:  if (w_wdone) w_nxt = MC_ST_IDLE;
            default:      w_nxt = MC_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MC_ST_IDLE;
            r_wcnt   <= 4'd0;
            r_ap_rec <= 1'b0;
            r_we     <= 1'b0;
            r_bank   <= 2'd0;
            r_row    <= 13'd0;
        end else begin
            r_state <= w_nxt;
            if (w_ld)
                r_wcnt <= w_ld_val;
            else if (!w_wdone)
                r_wcnt <= r_wcnt - 4'd1;
            // PRE_W is shared: remember whether it follows an auto-precharge COL.
            if (w_nxt == MC_ST_PRE_W && r_state != MC_ST_PRE_W)
                r_ap_rec <= (r_state == MC_ST_COL);
            if (r_state == MC_ST_IDLE && w_nxt != MC_ST_IDLE) begin
                r_we   <= req_we;
                r_bank <= req_bank;
                r_row  <= req_row;
            end
        end
    end

    always_comb begin
        cmd          = MC_CMD_NOP;
        cmd_ap       = 1'b0;
        req_ack      = 1'b0;
        rfr_ack      = 1'b0;
        bank_set     = 1'b0;
        bank_clr     = 1'b0;
        bank_clr_all = 1'b0;
        case (r_state)
            MC_ST_PRE: begin
                cmd      = MC_CMD_PRE;
                bank_clr = 1'b1;
            end
            MC_ST_ACT: begin
                cmd      = MC_CMD_ACT;
                bank_set = 1'b1;
            end
            MC_ST_COL: begin
                cmd     = r_we ? MC_CMD_WR : MC_CMD_RD;
                req_ack = 1'b1;
`ifdef MC_AUTO_PRECHARGE_EN
                cmd_ap   = 1'b1;
                bank_clr = 1'b1;
`endif
            end
            MC_ST_PALL: begin
                cmd          = MC_CMD_PREALL;
                bank_clr_all = 1'b1;
            end
            MC_ST_REF: begin
                cmd     = MC_CMD_REF;
                rfr_ack = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
